// File: rtl/life_array_engine_if.sv
// rtl/life_array_engine_if.sv - sequencer strobes, seed port and display/status bundle for life_array_engine
interface life_array_engine_if #(
  parameter int N  = 8,
  parameter int RW = 3
);
  logic          write_array;
  logic          run;
  logic [1:0]    pos;
  logic          write_mem;
  logic          seed_we;
  logic [RW-1:0] seed_row;
  logic [N-1:0]  seed_data;
  logic          seed_ready;
  logic          busy;
  logic          disp_valid;
  logic [RW-1:0] disp_row;
  logic [N-1:0]  disp_data;
  logic          gen_tick;
  logic [15:0]   gen_count;

  modport master (
    output write_array, run, pos, write_mem, seed_we, seed_row, seed_data,
    input  seed_ready, busy, disp_valid, disp_row, disp_data, gen_tick, gen_count
  );

  modport slave (
    input  write_array, run, pos, write_mem, seed_we, seed_row, seed_data,
    output seed_ready, busy, disp_valid, disp_row, disp_data, gen_tick, gen_count
  );
endinterface

// File: rtl/life_array_engine.sv
// rtl/life_array_engine.sv - toroidal Game of Life engine: banded next-gen compute, band display, whole-board commit
module life_array_engine #(
  parameter int N  = 8,
  parameter int RW = 3
) (
  input  logic               clk,
  input  logic               reset,
  life_array_engine_if.slave bus
);
  localparam int Q = N / 4;

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_cur [N];
  logic [N-1:0]  r_nxt [N];
  logic [3:0]    r_done_mask;
  logic [1:0]    r_band;
  logic [RW-1:0] r_row;
  logic          r_disp_valid;
  logic [RW-1:0] r_disp_row;
  logic [RW-1:0] r_disp_cnt;
  logic          r_gen_tick;
  logic [15:0]   r_gen_count;

  logic          w_busy;
  logic          w_calc_last;
  logic          w_commit;
  logic          w_seed;
  logic [RW-1:0] w_calc_row;
  logic [RW-1:0] w_up;
  logic [RW-1:0] w_dn;
  logic [N-1:0]  w_next_row;

  function automatic logic [N-1:0] f_life(input logic [N-1:0] a, input logic [N-1:0] m,
                                          input logic [N-1:0] b);
    logic [N-1:0] res;
    logic [3:0]   cnt;
    int           l;
    int           r;
    for (int c = 0; c < N; c++) begin
      l      = (c + N - 1) % N;
      r      = (c + 1) % N;
      cnt    = {3'b0, a[l]} + {3'b0, a[c]} + {3'b0, a[r]} +
               {3'b0, m[l]} + {3'b0, m[r]} +
               {3'b0, b[l]} + {3'b0, b[c]} + {3'b0, b[r]};
      res[c] = (cnt == 4'd3) | (m[c] & (cnt == 4'd2));
    end
    return res;
  endfunction

  assign w_busy     = (r_state == S_CALC);
  assign w_calc_row = RW'(r_band) * RW'(Q) + r_row;
  assign w_up       = (w_calc_row == '0) ? RW'(N - 1) : w_calc_row - 1'b1;
  assign w_dn       = (w_calc_row == RW'(N - 1)) ? '0 : w_calc_row + 1'b1;
  assign w_next_row = f_life(r_cur[w_up], r_cur[w_calc_row], r_cur[w_dn]);

  // Commit outranks a same-cycle seed write; both are blocked while a band is computing.
  assign w_commit = bus.write_mem & (bus.pos == 2'd3) & (r_done_mask == 4'hF) & ~w_busy;
  assign w_seed   = bus.seed_we & ~w_busy & ~w_commit;

  assign bus.busy       = w_busy;
  assign bus.seed_ready = ~w_busy;
  assign bus.disp_valid = r_disp_valid;
  assign bus.disp_row   = r_disp_row;
  assign bus.disp_data  = r_disp_valid ? r_cur[r_disp_row] : '0;
  assign bus.gen_tick   = r_gen_tick;
  assign bus.gen_count  = r_gen_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_calc_last  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.run) w_state_next = S_CALC;
      S_CALC: if (r_row == RW'(Q - 1)) begin
        w_state_next = S_IDLE;
        w_calc_last  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_cur[i] <= '0;
        r_nxt[i] <= '0;
      end
      r_done_mask <= '0;
      r_band      <= '0;
      r_row       <= '0;
      r_gen_tick  <= 1'b0;
      r_gen_count <= '0;
    end else begin
      r_gen_tick <= w_commit;
      if (r_state == S_IDLE && bus.run) begin
        r_band <= bus.pos;
        r_row  <= '0;
      end
      if (w_busy) begin
        r_nxt[w_calc_row] <= w_next_row;
        r_row             <= r_row + 1'b1;
      end
      if (w_commit) begin
        for (int i = 0; i < N; i++) r_cur[i] <= r_nxt[i];
        r_done_mask <= '0;
        r_gen_count <= r_gen_count + 16'd1;
      end else if (w_seed) begin
        r_cur[bus.seed_row] <= bus.seed_data;
        r_done_mask         <= '0;
      end else if (w_calc_last) begin
        r_done_mask[r_band] <= 1'b1;
      end
    end
  end

  // A fresh write_array always restarts the stream, even mid-band.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_disp_valid <= 1'b0;
      r_disp_row   <= '0;
      r_disp_cnt   <= '0;
    end else if (bus.write_array) begin
      r_disp_valid <= 1'b1;
      r_disp_row   <= RW'(bus.pos) * RW'(Q);
      r_disp_cnt   <= '0;
    end else if (r_disp_valid) begin
      if (r_disp_cnt == RW'(Q - 1)) begin
        r_disp_valid <= 1'b0;
      end else begin
        r_disp_row <= r_disp_row + 1'b1;
        r_disp_cnt <= r_disp_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_life_array_engine.sv
// tb/tb_life_array_engine.sv - directed self-checking bench for life_array_engine (N=8)
module tb_life_array_engine;
  logic       clk = 1'b0;
  logic       reset;
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] rd_board [8];
  logic [7:0] exp_board [8];

  life_array_engine_if #(.N(8), .RW(3)) bus ();
  life_array_engine #(.N(8), .RW(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed(input logic [2:0] row, input logic [7:0] data);
    bus.seed_we = 1'b1; bus.seed_row = row; bus.seed_data = data;
    tick();
    bus.seed_we = 1'b0;
  endtask

  task automatic run_band(input logic [1:0] b);
    bus.run = 1'b1; bus.pos = b;
    tick();
    bus.run = 1'b0;
    tick();
    tick();
  endtask

  task automatic commit();
    bus.write_mem = 1'b1; bus.pos = 2'd3;
    tick();
    bus.write_mem = 1'b0;
  endtask

  task automatic run_gen();
    for (int b = 0; b < 4; b++) run_band(2'(b));
    commit();
  endtask

  task automatic read_board();
    for (int p = 0; p < 4; p++) begin
      bus.write_array = 1'b1; bus.pos = 2'(p);
      tick();
      bus.write_array = 1'b0;
      for (int j = 0; j < 2; j++) begin
        rd_board[p*2+j] = bus.disp_valid ? bus.disp_data : 8'hxx;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_total++; if (bus.seed_ready !== 1'b1) $display("FAIL reset_seed_ready got %b want 1", bus.seed_ready); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.disp_valid !== 1'b0) $display("FAIL reset_disp_valid got %b want 0", bus.disp_valid); else n_pass++;
    n_total++; if (bus.gen_count !== 16'd0) $display("FAIL reset_gen_count got %0d want 0", bus.gen_count); else n_pass++;
    n_total++; if (bus.disp_data !== 8'h00) $display("FAIL reset_disp_data got %h want 00", bus.disp_data); else n_pass++;
    n_total++; if (bus.gen_tick !== 1'b0) $display("FAIL reset_gen_tick got %b want 0", bus.gen_tick); else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_blinker();
    seed(3'd3, 8'h10); seed(3'd4, 8'h10); seed(3'd5, 8'h10);
    for (int b = 0; b < 4; b++) run_band(2'(b));
    commit();
    n_total++; if (bus.gen_tick !== 1'b1) $display("FAIL blinker_tick_hi got %b want 1", bus.gen_tick); else n_pass++;
    n_total++; if (bus.gen_count !== 16'd1) $display("FAIL blinker_count got %0d want 1", bus.gen_count); else n_pass++;
    tick();
    n_total++; if (bus.gen_tick !== 1'b0) $display("FAIL blinker_tick_lo got %b want 0", bus.gen_tick); else n_pass++;
    read_board();
    for (int r = 0; r < 8; r++) begin
      n_total++;
      if (rd_board[r] !== ((r == 4) ? 8'h38 : 8'h00))
        $display("FAIL blinker_row%0d got %h want %h", r, rd_board[r], (r == 4) ? 8'h38 : 8'h00);
      else n_pass++;
    end
  endtask

  task automatic test_glider_wrap();
    for (int r = 0; r < 8; r++) exp_board[r] = 8'h00;
    exp_board[6] = 8'h80; exp_board[7] = 8'h01; exp_board[0] = 8'hC1;
    for (int r = 0; r < 8; r++) seed(3'(r), exp_board[r]);
    for (int g = 0; g < 4; g++) run_gen();
    for (int r = 0; r < 8; r++) exp_board[r] = 8'h00;
    exp_board[7] = 8'h01; exp_board[0] = 8'h02; exp_board[1] = 8'h83;
    read_board();
    for (int r = 0; r < 8; r++) begin
      n_total++;
      if (rd_board[r] !== exp_board[r]) $display("FAIL glider_row%0d got %h want %h", r, rd_board[r], exp_board[r]);
      else n_pass++;
    end
    n_total++; if (bus.gen_count !== 16'd5) $display("FAIL glider_count got %0d want 5", bus.gen_count); else n_pass++;
  endtask

  task automatic test_incomplete_commit();
    for (int b = 0; b < 3; b++) run_band(2'(b));
    commit();
    n_total++; if (bus.gen_tick !== 1'b0) $display("FAIL incomplete_tick got %b want 0", bus.gen_tick); else n_pass++;
    n_total++; if (bus.gen_count !== 16'd5) $display("FAIL incomplete_count got %0d want 5", bus.gen_count); else n_pass++;
    n_total++; if (dut.r_done_mask !== 4'h7) $display("FAIL incomplete_mask got %h want 7", dut.r_done_mask); else n_pass++;
    read_board();
    for (int r = 0; r < 8; r++) begin
      n_total++;
      if (rd_board[r] !== exp_board[r]) $display("FAIL incomplete_row%0d got %h want %h", r, rd_board[r], exp_board[r]);
      else n_pass++;
    end
    run_band(2'd3);
    commit();
    n_total++; if (bus.gen_tick !== 1'b1) $display("FAIL complete_tick got %b want 1", bus.gen_tick); else n_pass++;
    n_total++; if (bus.gen_count !== 16'd6) $display("FAIL complete_count got %0d want 6", bus.gen_count); else n_pass++;
  endtask

  task automatic test_seed_busy();
    for (int r = 0; r < 8; r++) seed(3'(r), (r == 2) ? 8'h0F : 8'h00);
    run_band(2'd1);
    run_band(2'd2);
    bus.run = 1'b1; bus.pos = 2'd0;
    tick();
    bus.run = 1'b0;
    bus.seed_we = 1'b1; bus.seed_row = 3'd2; bus.seed_data = 8'hFF;
    #1;
    n_total++; if (bus.seed_ready !== 1'b0) $display("FAIL busy_seed_ready got %b want 0", bus.seed_ready); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL busy_flag got %b want 1", bus.busy); else n_pass++;
    tick();
    bus.seed_we = 1'b0;
    tick();
    n_total++; if (bus.seed_ready !== 1'b1) $display("FAIL busy_ready_back got %b want 1", bus.seed_ready); else n_pass++;
    n_total++; if (dut.r_done_mask !== 4'h7) $display("FAIL busy_mask got %h want 7", dut.r_done_mask); else n_pass++;
    read_board();
    n_total++; if (rd_board[2] !== 8'h0F) $display("FAIL busy_row2 got %h want 0f", rd_board[2]); else n_pass++;
  endtask

  task automatic test_display();
    seed(3'd0, 8'h81); seed(3'd4, 8'hA5); seed(3'd5, 8'h3C);
    bus.write_array = 1'b1; bus.pos = 2'd2;
    tick();
    bus.write_array = 1'b0;
    n_total++; if ({bus.disp_valid, bus.disp_row, bus.disp_data} !== {1'b1, 3'd4, 8'hA5})
      $display("FAIL disp_first got v=%b r=%0d d=%h want v=1 r=4 d=a5", bus.disp_valid, bus.disp_row, bus.disp_data); else n_pass++;
    tick();
    n_total++; if ({bus.disp_valid, bus.disp_row, bus.disp_data} !== {1'b1, 3'd5, 8'h3C})
      $display("FAIL disp_second got v=%b r=%0d d=%h want v=1 r=5 d=3c", bus.disp_valid, bus.disp_row, bus.disp_data); else n_pass++;
    tick();
    n_total++; if (bus.disp_valid !== 1'b0) $display("FAIL disp_end got %b want 0", bus.disp_valid); else n_pass++;
    bus.write_array = 1'b1; bus.pos = 2'd2;
    tick();
    bus.pos = 2'd0;
    tick();
    bus.write_array = 1'b0;
    n_total++; if ({bus.disp_valid, bus.disp_row, bus.disp_data} !== {1'b1, 3'd0, 8'h81})
      $display("FAIL disp_restart got v=%b r=%0d d=%h want v=1 r=0 d=81", bus.disp_valid, bus.disp_row, bus.disp_data); else n_pass++;
    tick();
    n_total++; if ({bus.disp_valid, bus.disp_row, bus.disp_data} !== {1'b1, 3'd1, 8'h00})
      $display("FAIL disp_restart2 got v=%b r=%0d d=%h want v=1 r=1 d=00", bus.disp_valid, bus.disp_row, bus.disp_data); else n_pass++;
    tick();
    n_total++; if (bus.disp_valid !== 1'b0) $display("FAIL disp_restart_end got %b want 0", bus.disp_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_calc();
    bus.run = 1'b1; bus.pos = 2'd1;
    bus.write_array = 1'b1;
    tick();
    bus.run = 1'b0; bus.write_array = 1'b0;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL midrst_pre_busy got %b want 1", bus.busy); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.seed_ready !== 1'b1) $display("FAIL midrst_seed_ready got %b want 1", bus.seed_ready); else n_pass++;
    n_total++; if (bus.gen_count !== 16'd0) $display("FAIL midrst_gen_count got %0d want 0", bus.gen_count); else n_pass++;
    n_total++; if (bus.disp_valid !== 1'b0) $display("FAIL midrst_disp_valid got %b want 0", bus.disp_valid); else n_pass++;
    n_total++; if (bus.disp_data !== 8'h00) $display("FAIL midrst_disp_data got %h want 00", bus.disp_data); else n_pass++;
    #3 reset = 1'b1;
    tick();
    read_board();
    n_total++; if (rd_board[4] !== 8'h00) $display("FAIL midrst_row4 got %h want 00", rd_board[4]); else n_pass++;
    n_total++; if (rd_board[0] !== 8'h00) $display("FAIL midrst_row0 got %h want 00", rd_board[0]); else n_pass++;
  endtask

  initial begin
    bus.write_array = 1'b0; bus.run = 1'b0; bus.pos = 2'd0; bus.write_mem = 1'b0;
    bus.seed_we = 1'b0; bus.seed_row = 3'd0; bus.seed_data = 8'h00;
    test_reset();
    test_blinker();
    test_glider_wrap();
    test_incomplete_commit();
    test_seed_busy();
    test_display();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/life_array_engine.md
# life_array_engine

Generation engine for a toroidal N×N Game of Life board. It sits directly downstream of the phase sequencer and consumes its `write_array`, `run`, `pos` and `write_mem` strobes. Each `pos` value selects one horizontal band of N/4 rows. The engine streams the selected band out for display, computes that band's next generation row by row, and commits the whole board once all four bands are done.

## Interface
Parameters:
- `N`, 8: board width and height in cells. Must be a multiple of 4 and ≥ 4.
- `RW`, 3: row index width, equal to clog2(N).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. Low clears all state immediately.
- `write_array`  in  1  strobe: stream band `pos` of the current board to the display port.
- `run`  in  1  strobe: compute the next generation of band `pos`.
- `pos`  in  2  band select; band p covers rows p·N/4 … p·N/4+N/4−1.
- `write_mem`  in  1  strobe: commit request, acted on only when `pos`=3.
- `seed_we`  in  1  host write of one current-board row.
- `seed_row`  in  RW  row index for the seed write.
- `seed_data`  in  N  row contents; bit c is column c, 1 = alive.
- `seed_ready`  out  1  high when `busy`=0. A seed write is accepted only when `seed_we & seed_ready`.
- `busy`  out  1  band computation in progress.
- `disp_valid`  out  1  display row valid.
- `disp_row`  out  RW  index of the row on `disp_data`.
- `disp_data`  out  N  current-board row contents.
- `gen_tick`  out  1  one-cycle pulse after a commit.
- `gen_count`  out  16  committed generations; wraps from 0xFFFF to 0.

## Operation
- Storage:
  - `cur` holds the current board; `nxt` holds the next board.
  - `done_mask[3:0]` records which bands have been computed for the pending generation.
- Reset values: `cur`, `nxt`, `done_mask`, `gen_count` = 0; all outputs = 0 except `seed_ready`, which is 1.
- Compute FSM, states IDLE and CALC:
  - IDLE → CALC on `run`: latch band b=`pos`, row counter r=0.
  - In CALC, each cycle writes `nxt` row b·N/4+r and increments r.
  - After r=N/4−1: return to IDLE and set `done_mask[b]`.
  - `run` is ignored while in CALC.
- Cell rule:
  - Neighbour count is the 4-bit sum of 8 neighbours, indices taken mod N (toroidal wrap on both row and column).
  - Next state = (count==3) | (alive & count==2).
  - A row computation reads only `cur`.
- Display FSM, independent of the compute FSM:
  - On `write_array`, stream rows p·N/4 … p·N/4+N/4−1 of `cur`, one row per cycle.
  - A new `write_array` during a stream restarts it at the new band.
- Commit:
  - Condition: `write_mem` & `pos`==3 & `done_mask`==4'hF & `busy`==0.
  - Action: `cur` ← `nxt`, clear `done_mask`, `gen_count`+1, pulse `gen_tick`.
  - If the condition is not met, there is no effect and `done_mask` is kept.
  - `write_mem` with `pos`≠3 is ignored.
- Seed write:
  - `cur[seed_row]` ← `seed_data` and `done_mask` cleared, because `nxt` is now stale.
  - Dropped if `busy`=1.
- Simultaneous events:
  - A seed write and a commit in the same cycle: the commit wins and the seed write is dropped.
  - A `run` for a band already marked done recomputes that band; the result is identical.
- Reset asserted mid-CALC or mid-stream aborts immediately. No partial commit occurs.

## Timing
- `run` sampled at edge k:
  - `busy` is high for cycles k+1 … k+N/4.
  - The last `nxt` row is written at edge k+N/4.
  - `done_mask[b]` is set at that same edge.
- `write_array` sampled at edge k: `disp_valid` is high for cycles k+1 … k+N/4, rows in ascending order.
- Commit at edge k:
  - New `cur` is visible from cycle k+1.
  - `gen_tick` is high for cycle k+1 only.
  - `gen_count` is updated in cycle k+1.
- `seed_ready` is the combinational inverse of the registered `busy`.
- With the sequencer's 4-cycle phase and N=8, CALC (2 cycles) always finishes before the next `write_mem`.

## Test plan
- Blinker: seed rows 3–5 with bit 4 set (vertical line), run bands 0–3, then `write_mem` with `pos`=3. Rows 3 and 5 must read 0 and row 4 must read 0x38; `gen_count`=1, `gen_tick` high for exactly 1 cycle.
- Glider wrap: seed a glider in the corner at rows 6–7/0 and columns 6–7/0, then run 4 full generations. The board must equal the seed shifted by (+1,+1) mod 8.
- Incomplete commit: run bands 0–2 only, then `write_mem` with `pos`=3. `cur` and `gen_count` must be unchanged and `done_mask` must stay 4'h7. Then run band 3 and commit; the commit must succeed.
- Seed during busy: assert `seed_we` on the cycle after a `run`. `seed_ready`=0, row unchanged, `done_mask` unaffected.
- Display: after seeding, `write_array` with `pos`=2 gives `disp_valid` for 2 cycles with `disp_row`=4 then 5 and matching data. A restart with `pos`=0 mid-stream must switch to row 0.
- Reset mid-CALC: pull `reset` low asynchronously between clock edges during `busy`. All outputs must drop to reset values immediately, with `seed_ready`=1 and `gen_count`=0.
